iomem_dma: RTL

IOMEM_DMA -- requirements
Module: iomem_dma

---
 rtl/iomem_dma_if.sv | 35 +++
 rtl/iomem_dma.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/iomem_dma_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : iomem_dma_if
//  Brief    : Config responder port and peripheral initiator bus of iomem_dma.
//  Revision : 1.0  initial release
// ============================================================================
interface iomem_dma_if;
   logic        iomem_valid;
   logic        iomem_ready;
   logic [3:0]  iomem_wstrb;
   logic [31:0] iomem_addr;
   logic [31:0] iomem_wdata;
   logic [31:0] iomem_rdata;

   logic        m_valid;
   logic        m_ready;
   logic [3:0]  m_wstrb;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic [31:0] m_rdata;

   // DMA side: responder on the config port, initiator on the peripheral bus
   modport slave (
      input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata, m_ready, m_rdata,
      output iomem_ready, iomem_rdata, m_valid, m_wstrb, m_addr, m_wdata
   );

   // Environment side: CPU on the config port, peripheral on the bus
   modport master (
      output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata, m_ready, m_rdata,
      input  iomem_ready, iomem_rdata, m_valid, m_wstrb, m_addr, m_wdata
   );
endinterface
`default_nettype wire

// File: rtl/iomem_dma.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : iomem_dma
//  Brief    : Word-copy DMA with a 4-register config port; optional fill mode
//             enabled by macro IOMEM_DMA_FILL_EN.
//  Revision : 1.0  initial release
// ============================================================================
module iomem_dma #(
   parameter int MAX_LEN_BITS = 16
) (
   input  logic       clk,
   input  logic       resetn,
   iomem_dma_if.slave bus,
   output logic       irq
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      FIN  = 2'd3
   } state_t;

   state_t                  state, state_nxt;
   logic [31:0]             src, dst, work_src, work_dst, data_q, rdata_q;
   logic [MAX_LEN_BITS-1:0] len, count;
   logic                    done, aborted, abort_pend, fill_mode, ready_q;
   logic [31:0]             len_ext, rd_mux, status, src_merged, dst_merged, len_merged;
   logic [1:0]              reg_sel;
   logic                    cfg_acc, cfg_wr, busy, ctrl_wr;
   logic                    start_req, abort_req, fill_req, start_ok, abort_now;
   logic                    addr_unused;

   function automatic logic [31:0] byte_merge(input logic [31:0] old,
                                              input logic [31:0] wd,
                                              input logic [3:0]  ws);
      logic [31:0] res;
      for (int i = 0; i < 4; i++)
         res[8*i +: 8] = ws[i] ? wd[8*i +: 8] : old[8*i +: 8];
      return res;
   endfunction

   assign addr_unused = ^{bus.iomem_addr[31:4], bus.iomem_addr[1:0]};
   assign reg_sel     = bus.iomem_addr[3:2];

   // The access completes in the ready cycle; side effects land on its closing edge
   assign cfg_acc   = bus.iomem_valid && ready_q;
   assign cfg_wr    = cfg_acc && (bus.iomem_wstrb != 4'b0000);
   assign busy      = (state == RD) || (state == WR);
   assign ctrl_wr   = cfg_wr && (reg_sel == 2'd3) && bus.iomem_wstrb[0];
   assign start_req = ctrl_wr && bus.iomem_wdata[0];
   assign abort_req = ctrl_wr && bus.iomem_wdata[1];
   assign start_ok  = start_req && (state == IDLE);
   assign abort_now = abort_pend || (abort_req && busy);

`ifdef IOMEM_DMA_FILL_EN
   logic [31:0] fill_pat;
   assign fill_req = bus.iomem_wdata[2];
`else
   assign fill_req = 1'b0;
`endif

   assign src_merged = byte_merge(src, bus.iomem_wdata, bus.iomem_wstrb) & 32'hFFFF_FFFC;
   assign dst_merged = byte_merge(dst, bus.iomem_wdata, bus.iomem_wstrb) & 32'hFFFF_FFFC;
   assign len_merged = byte_merge(len_ext, bus.iomem_wdata, bus.iomem_wstrb);

   always_comb begin
      len_ext                    = '0;
      len_ext[MAX_LEN_BITS-1:0]  = len;
   end

   assign status = {28'd0, fill_mode, aborted, done, busy};

   always_comb begin
      rd_mux = '0;
      case (reg_sel)
         2'd0:    rd_mux = src;
         2'd1:    rd_mux = dst;
         2'd2:    rd_mux = len_ext;
         default: rd_mux = status;
      endcase
   end

   assign bus.iomem_ready = ready_q;
   assign bus.iomem_rdata = rdata_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      bus.m_valid = 1'b0;
      bus.m_wstrb = 4'h0;
      bus.m_addr  = '0;
      bus.m_wdata = '0;
      irq         = 1'b0;
      case (state)
         IDLE: begin
            if (start_ok) begin
               if (len == '0)    state_nxt = FIN;
               else if (fill_req) state_nxt = WR;
               else              state_nxt = RD;
            end
         end
         RD: begin
            bus.m_valid = 1'b1;
            bus.m_addr  = work_src;
            if (bus.m_ready) state_nxt = abort_now ? FIN : WR;
         end
         WR: begin
            bus.m_valid = 1'b1;
            bus.m_wstrb = 4'hF;
            bus.m_addr  = work_dst;
            bus.m_wdata = data_q;
            if (bus.m_ready) begin
               if (abort_now || (count == MAX_LEN_BITS'(1))) state_nxt = FIN;
               else if (fill_mode)                           state_nxt = WR;
               else                                          state_nxt = RD;
            end
         end
         FIN: begin
            irq       = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ready_q    <= 1'b0;
         rdata_q    <= '0;
         src        <= '0;
         dst        <= '0;
         len        <= '0;
         work_src   <= '0;
         work_dst   <= '0;
         count      <= '0;
         data_q     <= '0;
         done       <= 1'b0;
         aborted    <= 1'b0;
         abort_pend <= 1'b0;
         fill_mode  <= 1'b0;
      end else begin
         ready_q <= bus.iomem_valid && !ready_q;
         rdata_q <= (bus.iomem_valid && !ready_q) ? rd_mux : 32'd0;

         if (cfg_wr && !busy) begin
            case (reg_sel)
               2'd0:    src <= src_merged;
               2'd1:    dst <= dst_merged;
               2'd2:    len <= len_merged[MAX_LEN_BITS-1:0];
               default: ;
            endcase
         end

         if (start_ok) begin
            work_src   <= src;
            work_dst   <= dst;
            count      <= len;
            done       <= 1'b0;
            aborted    <= 1'b0;
            abort_pend <= 1'b0;
            fill_mode  <= fill_req;
`ifdef IOMEM_DMA_FILL_EN
            if (fill_req) data_q <= fill_pat;
`endif
         end

         if (abort_req && busy) abort_pend <= 1'b1;

         if ((state == RD) && bus.m_ready) data_q <= bus.m_rdata;

         if ((state == WR) && bus.m_ready) begin
            work_src <= work_src + 32'd4;
            work_dst <= work_dst + 32'd4;
            count    <= count - MAX_LEN_BITS'(1);
         end

         // Completion flags are decided on the edge that enters FIN
         if ((state_nxt == FIN) && (state != FIN)) begin
            done       <= !abort_now;
            aborted    <= abort_now;
            abort_pend <= 1'b0;
         end
      end
   end

`ifdef IOMEM_DMA_FILL_EN
   // Fill pattern keeps the raw written value, including the low address bits
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         fill_pat <= '0;
      else if (cfg_wr && !busy && (reg_sel == 2'd0))
         fill_pat <= byte_merge(fill_pat, bus.iomem_wdata, bus.iomem_wstrb);
   end
`endif

endmodule
`default_nettype wire
